// File: rtl/arb_ctrl.sv
// Four-requester round-robin arbiter with bounded tenure: IDLE -> GRANT -> RELEASE,
// with a one-cycle turnaround after every tenure and a timeout pulse when a tenure is cut.
module arb_ctrl #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout,
  output logic [1:0] fsm_state
);

  // Handshake: req[i] is a level request held high for the whole tenure; gnt is the
  // registered one-hot answer; dropping req[gnt_id] ends the tenure on the next edge.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] gnt_n;
  logic [1:0] id_n;
  logic       to_n;

  logic       found;
  logic [1:0] winner;
  logic [1:0] idx;

  // Rotating search: ptr, ptr+1, ... mod 4, first set request wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    id_n    = gnt_id;
    ptr_n   = ptr;
    cnt_n   = cnt;
    to_n    = 1'b0;
    case (state)
      IDLE, RELEASE: begin
        gnt_n = 4'b0000;
        if (en && found) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << winner;
          id_n    = winner;
          ptr_n   = winner + 2'd1;
          cnt_n   = 8'd0;
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        // A dropped request wins over a coincident timeout.
        if (!req[gnt_id]) begin
          state_n = RELEASE;
          gnt_n   = 4'b0000;
        end else if (cnt >= LAST) begin
          state_n = RELEASE;
          gnt_n   = 4'b0000;
          to_n    = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      cnt     <= 8'd0;
      gnt     <= 4'b0000;
      gnt_id  <= 2'd0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      gnt     <= gnt_n;
      gnt_id  <= id_n;
      timeout <= to_n;
    end
  end

  assign busy      = |gnt;
  assign fsm_state = state;

endmodule

// File: tb/tb_arb_ctrl.sv
// Directed bench for arb_ctrl: each step drives req/en, queues the expected
// {state, gnt, gnt_id, busy, timeout} after the next edge, then pops and compares.
module tb_arb_ctrl;

  localparam int MH = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GNT  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;
  logic [1:0] fsm_state;

  logic [9:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  arb_ctrl #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout),
    .fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input logic [1:0] st, input logic [3:0] g, input logic [1:0] id,
                          input logic to);
    exp_q.push_back({st, g, id, |g, to});
  endtask

  task automatic check(input string tag);
    logic [9:0] obs;
    logic [9:0] exp;
    obs = {fsm_state, gnt, gnt_id, busy, timeout};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s obs=%h exp=<empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s obs={st=%0d gnt=%b id=%0d busy=%b to=%b} exp={st=%0d gnt=%b id=%0d busy=%b to=%b}",
               tag, obs[9:8], obs[7:4], obs[3:2], obs[1], obs[0],
               exp[9:8], exp[7:4], exp[3:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic e, input logic [1:0] st,
                     input logic [3:0] g, input logic [1:0] id, input logic to,
                     input string tag);
    req = r;
    en  = e;
    push_exp(st, g, id, to);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear and that it holds across
  // an edge with requests pending, then releases it at a falling edge.
  task automatic do_reset(input logic [3:0] r, input string tag);
    req   = r;
    en    = 1'b1;
    rst_n = 1'b0;
    #1;
    push_exp(S_IDLE, 4'b0000, 2'd0, 1'b0);
    check({tag, "_async"});
    @(posedge clk);
    #1;
    push_exp(S_IDLE, 4'b0000, 2'd0, 1'b0);
    check({tag, "_held"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    req   = 4'b0000;
    @(negedge clk);

    // Full rotation with all requests held: 0,1,2,3,0, each cut at MH cycles.
    do_reset(4'b0000, "rst1");
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < MH; c++)
        cyc(4'b1111, 1'b1, S_GNT, 4'b0001 << (k % 4), 2'(k % 4), 1'b0, "rot_grant");
      cyc(4'b1111, 1'b1, S_REL, 4'b0000, 2'(k % 4), 1'b1, "rot_timeout");
    end
    cyc(4'b0000, 1'b1, S_IDLE, 4'b0000, 2'd0, 1'b0, "rot_idle");

    // Short tenure: 3 grant cycles, then release and idle, no timeout.
    do_reset(4'b0000, "rst2");
    for (int c = 0; c < 3; c++)
      cyc(4'b0100, 1'b1, S_GNT, 4'b0100, 2'd2, 1'b0, "short_grant");
    cyc(4'b0000, 1'b1, S_REL,  4'b0000, 2'd2, 1'b0, "short_release");
    cyc(4'b0000, 1'b1, S_IDLE, 4'b0000, 2'd2, 1'b0, "short_idle");

    // Requester 1 over-holds with 3 pending: cut at MH, then 3 must win.
    do_reset(4'b0000, "rst3");
    for (int c = 0; c < MH; c++)
      cyc(4'b1010, 1'b1, S_GNT, 4'b0010, 2'd1, 1'b0, "hold_grant1");
    cyc(4'b1010, 1'b1, S_REL, 4'b0000, 2'd1, 1'b1, "hold_timeout");
    cyc(4'b1010, 1'b1, S_GNT, 4'b1000, 2'd3, 1'b0, "hold_grant3");
    cyc(4'b1010, 1'b1, S_GNT, 4'b1000, 2'd3, 1'b0, "hold_grant3");
    cyc(4'b1000, 1'b1, S_GNT, 4'b1000, 2'd3, 1'b0, "hold_grant3_req1_low");
    cyc(4'b0000, 1'b1, S_REL,  4'b0000, 2'd3, 1'b0, "hold_release3");
    cyc(4'b0000, 1'b1, S_IDLE, 4'b0000, 2'd3, 1'b0, "hold_idle");

    // Enable gating: no grant while en=0; en falling mid-tenure does not shorten it.
    do_reset(4'b0000, "rst4");
    for (int c = 0; c < 3; c++)
      cyc(4'b0011, 1'b0, S_IDLE, 4'b0000, 2'd0, 1'b0, "en_low_idle");
    cyc(4'b0011, 1'b1, S_GNT, 4'b0001, 2'd0, 1'b0, "en_rise_grant");
    for (int c = 1; c < MH; c++)
      cyc(4'b0011, 1'b0, S_GNT, 4'b0001, 2'd0, 1'b0, "en_fall_tenure");
    cyc(4'b0011, 1'b0, S_REL,  4'b0000, 2'd0, 1'b1, "en_fall_timeout");
    cyc(4'b0011, 1'b0, S_IDLE, 4'b0000, 2'd0, 1'b0, "en_fall_idle");

    // Request drop coincident with the last tenure cycle: release, no timeout.
    do_reset(4'b0000, "rst5");
    for (int c = 0; c < MH; c++)
      cyc(4'b0001, 1'b1, S_GNT, 4'b0001, 2'd0, 1'b0, "edge_grant");
    cyc(4'b0000, 1'b1, S_REL,  4'b0000, 2'd0, 1'b0, "edge_release_no_to");
    cyc(4'b0000, 1'b1, S_IDLE, 4'b0000, 2'd0, 1'b0, "edge_idle");

    // Reset in the middle of a tenure, then arbitration restarts from ptr=0.
    do_reset(4'b0000, "rst6");
    for (int c = 0; c < 6; c++)
      cyc(4'b0100, 1'b1, S_GNT, 4'b0100, 2'd2, 1'b0, "mid_grant");
    do_reset(4'b0110, "rst_mid");
    cyc(4'b0110, 1'b1, S_GNT, 4'b0010, 2'd1, 1'b0, "post_reset_grant");
    cyc(4'b0100, 1'b1, S_REL, 4'b0000, 2'd1, 1'b0, "post_reset_release");
    cyc(4'b0100, 1'b1, S_GNT, 4'b0100, 2'd2, 1'b0, "post_reset_next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
